// File: rtl/apb_arbiter.sv
// apb_arbiter: round-robin sharing of one downstream APB bus among N_REQ requesters.
// Each transfer costs one extra wait state; an optional ACCESS timeout ends a hung access with PSLVERR.
module apb_arbiter #(
    parameter int N_REQ   = 2,
    parameter int AW_APB  = 32,
    parameter int DW_APB  = 32,
    parameter int TIMEOUT = 256
) (
    input  logic                        pclk,
    input  logic                        presetn,
    input  logic [N_REQ-1:0]            s_psel,
    input  logic [N_REQ-1:0]            s_penable,
    input  logic [N_REQ-1:0]            s_pwrite,
    input  logic [N_REQ*AW_APB-1:0]     s_paddr,
    input  logic [N_REQ*DW_APB-1:0]     s_pwdata,
    input  logic [N_REQ*DW_APB/8-1:0]   s_pstrb,
    input  logic [N_REQ*3-1:0]          s_pprot,
    output logic [N_REQ-1:0]            s_pready,
    output logic [DW_APB-1:0]           s_prdata,
    output logic [N_REQ-1:0]            s_pslverr,
    output logic                        m_psel,
    output logic                        m_penable,
    output logic                        m_pwrite,
    output logic [AW_APB-1:0]           m_paddr,
    output logic [DW_APB-1:0]           m_pwdata,
    output logic [DW_APB/8-1:0]         m_pstrb,
    output logic [2:0]                  m_pprot,
    input  logic                        m_pready,
    input  logic [DW_APB-1:0]           m_prdata,
    input  logic                        m_pslverr,
    output logic [N_REQ-1:0]            grant,
    output logic                        busy
);
    localparam int SW = DW_APB / 8;
    localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;

    state_t          state_q;
    logic [IW-1:0]   rr_ptr_q, idx_q;
    logic [CW-1:0]   cnt_q;
    logic            m_psel_q, m_penable_q, m_pwrite_q;
    logic [AW_APB-1:0] m_paddr_q;
    logic [DW_APB-1:0] m_pwdata_q;
    logic [SW-1:0]   m_pstrb_q;
    logic [2:0]      m_pprot_q;
    logic [N_REQ-1:0] grant_q;

    logic [IW-1:0]   win_d, ptr_d, cand;
    logic            found;
    logic            timeout_hit, done;
    logic [N_REQ-1:0] resp_lane;

    // First requesting lane at or after rr_ptr, wrapping modulo N_REQ.
    always_comb begin
        win_d = rr_ptr_q;
        found = 1'b0;
        cand  = '0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            cand = IW'((32'(rr_ptr_q) + i) % N_REQ);
            if (!found && s_psel[cand]) begin
                win_d = cand;
                found = 1'b1;
            end
        end
    end

    assign ptr_d       = (idx_q == IW'(N_REQ - 1)) ? '0 : idx_q + 1'b1;
    assign timeout_hit = (TIMEOUT != 0) && (state_q == ACCESS) && !m_pready
                         && (cnt_q == CW'(TIMEOUT - 1));
    assign done        = (state_q == ACCESS) && (m_pready || timeout_hit);

    // A requester that has left its access phase no longer receives the response pulse.
    assign resp_lane = grant_q & s_psel & s_penable;
    assign s_pready  = done ? resp_lane : '0;
    assign s_pslverr = (done && (m_pslverr || timeout_hit)) ? resp_lane : '0;
    assign s_prdata  = timeout_hit ? '0 : m_prdata;

    assign m_psel    = m_psel_q;
    assign m_penable = m_penable_q;
    assign m_pwrite  = m_pwrite_q;
    assign m_paddr   = m_paddr_q;
    assign m_pwdata  = m_pwdata_q;
    assign m_pstrb   = m_pstrb_q;
    assign m_pprot   = m_pprot_q;
    assign grant     = grant_q;
    assign busy      = m_psel_q;

    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            state_q     <= IDLE;
            rr_ptr_q    <= '0;
            idx_q       <= '0;
            cnt_q       <= '0;
            m_psel_q    <= 1'b0;
            m_penable_q <= 1'b0;
            m_pwrite_q  <= 1'b0;
            m_paddr_q   <= '0;
            m_pwdata_q  <= '0;
            m_pstrb_q   <= '0;
            m_pprot_q   <= '0;
            grant_q     <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (found) begin
                        state_q    <= SETUP;
                        idx_q      <= win_d;
                        m_psel_q   <= 1'b1;
                        grant_q    <= N_REQ'(1) << win_d;
                        m_pwrite_q <= s_pwrite[win_d];
                        m_paddr_q  <= s_paddr[win_d*AW_APB +: AW_APB];
                        m_pwdata_q <= s_pwdata[win_d*DW_APB +: DW_APB];
                        m_pstrb_q  <= s_pstrb[win_d*SW +: SW];
                        m_pprot_q  <= s_pprot[win_d*3 +: 3];
                    end
                end
                SETUP: begin
                    state_q     <= ACCESS;
                    m_penable_q <= 1'b1;
                    cnt_q       <= '0;
                end
                ACCESS: begin
                    if (done) begin
                        state_q     <= IDLE;
                        m_psel_q    <= 1'b0;
                        m_penable_q <= 1'b0;
                        grant_q     <= '0;
                        rr_ptr_q    <= ptr_d;
                        cnt_q       <= '0;
                    end else if (TIMEOUT != 0) begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_apb_arbiter.sv
// Self-checking bench for apb_arbiter: directed scenarios followed by randomized traffic
// checked against a transaction-level round-robin reference model.
module tb_apb_arbiter;
    localparam int N  = 4;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int SW = DW / 8;
    localparam int TO = 8;

    logic            pclk = 1'b0;
    logic            presetn = 1'b0;
    logic [N-1:0]    s_psel, s_penable, s_pwrite;
    logic [N*AW-1:0] s_paddr;
    logic [N*DW-1:0] s_pwdata;
    logic [N*SW-1:0] s_pstrb;
    logic [N*3-1:0]  s_pprot;
    logic [N-1:0]    s_pready, s_pslverr;
    logic [DW-1:0]   s_prdata;
    logic            m_psel, m_penable, m_pwrite;
    logic [AW-1:0]   m_paddr;
    logic [DW-1:0]   m_pwdata;
    logic [SW-1:0]   m_pstrb;
    logic [2:0]      m_pprot;
    logic            m_pready, m_pslverr;
    logic [DW-1:0]   m_prdata;
    logic [N-1:0]    grant;
    logic            busy;

    int checks = 0;
    int failures = 0;

    // Requester-side model state
    bit            req_act[N], req_en[N], req_new[N], req_wr[N];
    logic [AW-1:0] req_addr[N];
    logic [DW-1:0] req_wdata[N];
    logic [SW-1:0] req_strb[N];
    logic [2:0]    req_prot[N];
    int            waited[N];
    int            ptr, owner, last_w;
    logic [N-1:0]  last_rdy;
    bit            hold_mode, rand_mode;

    apb_arbiter #(.N_REQ(N), .AW_APB(AW), .DW_APB(DW), .TIMEOUT(TO)) dut (
        .pclk(pclk), .presetn(presetn),
        .s_psel(s_psel), .s_penable(s_penable), .s_pwrite(s_pwrite),
        .s_paddr(s_paddr), .s_pwdata(s_pwdata), .s_pstrb(s_pstrb), .s_pprot(s_pprot),
        .s_pready(s_pready), .s_prdata(s_prdata), .s_pslverr(s_pslverr),
        .m_psel(m_psel), .m_penable(m_penable), .m_pwrite(m_pwrite),
        .m_paddr(m_paddr), .m_pwdata(m_pwdata), .m_pstrb(m_pstrb), .m_pprot(m_pprot),
        .m_pready(m_pready), .m_prdata(m_prdata), .m_pslverr(m_pslverr),
        .grant(grant), .busy(busy)
    );

    always #5 pclk = ~pclk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Winner = requesting lane with the smallest forward distance from the pointer.
    function automatic int pick(input logic [N-1:0] req, input int p);
        int best = -1;
        int bd = N;
        for (int i = 0; i < N; i++)
            if (req[i] && ((i - p + N) % N) < bd) begin
                bd = (i - p + N) % N;
                best = i;
            end
        return best;
    endfunction

    task automatic apply_lanes();
        for (int i = 0; i < N; i++) begin
            s_psel[i]             = req_act[i];
            s_penable[i]          = req_act[i] & req_en[i];
            s_pwrite[i]           = req_wr[i];
            s_paddr[i*AW +: AW]   = req_addr[i];
            s_pwdata[i*DW +: DW]  = req_wdata[i];
            s_pstrb[i*SW +: SW]   = req_strb[i];
            s_pprot[i*3 +: 3]     = req_prot[i];
        end
    endtask

    task automatic set_req(input int i, input bit wr, input logic [AW-1:0] a,
                           input logic [DW-1:0] d, input logic [SW-1:0] s, input logic [2:0] p);
        req_act[i] = 1; req_en[i] = 0; req_new[i] = 1; req_wr[i] = wr;
        req_addr[i] = a; req_wdata[i] = d; req_strb[i] = s; req_prot[i] = p;
    endtask

    task automatic new_txn(input int i);
        set_req(i, 1'($urandom_range(0, 1)), AW'($urandom), DW'($urandom),
                SW'($urandom), 3'($urandom_range(0, 7)));
        req_new[i] = 0;
    endtask

    // Advance every requester by one cycle, reacting to last cycle's response.
    task automatic lane_update();
        for (int i = 0; i < N; i++) begin
            if (last_rdy[i]) begin
                if (hold_mode || (rand_mode && $urandom_range(0, 1) == 1)) new_txn(i);
                else begin req_act[i] = 0; req_en[i] = 0; end
            end else if (req_act[i]) begin
                if (req_new[i]) req_new[i] = 0;
                else req_en[i] = 1;
            end else if (rand_mode && i != owner && $urandom_range(0, 3) == 0) begin
                new_txn(i);
            end
            if (!req_act[i]) waited[i] = 0;
        end
        last_rdy = '0;
    endtask

    task automatic check_zero();
        chk("rst_m_psel", m_psel, 0);       chk("rst_m_penable", m_penable, 0);
        chk("rst_m_pwrite", m_pwrite, 0);   chk("rst_m_paddr", m_paddr, 0);
        chk("rst_m_pwdata", m_pwdata, 0);   chk("rst_m_pstrb", m_pstrb, 0);
        chk("rst_m_pprot", m_pprot, 0);     chk("rst_s_pready", s_pready, 0);
        chk("rst_s_pslverr", s_pslverr, 0); chk("rst_grant", grant, 0);
        chk("rst_busy", busy, 0);
    endtask

    task automatic do_reset();
        presetn = 0;
        for (int i = 0; i < N; i++) begin
            req_act[i] = 0; req_en[i] = 0; req_new[i] = 0; req_wr[i] = 0;
            req_addr[i] = '0; req_wdata[i] = '0; req_strb[i] = '0; req_prot[i] = '0;
            waited[i] = 0;
        end
        apply_lanes();
        m_pready = 0; m_pslverr = 0; m_prdata = '0;
        ptr = 0; owner = -1; last_rdy = '0; hold_mode = 0; rand_mode = 0;
        repeat (2) @(posedge pclk);
        #1 presetn = 1;
    endtask

    // One transfer: idle cycle(s) until a request, SETUP, then ACCESS with `waits` slave
    // wait states (or until the timeout fires).
    task automatic run_transfer(input int waits, input logic err, input bit fix_rd,
                                input logic [DW-1:0] rd);
        bit            found = 0;
        bit            fin, to;
        int            w;
        logic [AW-1:0] ea;
        logic [DW-1:0] ed;
        logic [SW-1:0] es;
        logic [2:0]    ep;
        logic          ewr;
        logic [N-1:0]  oh, exp_rdy;
        for (int n = 0; n < 40 && !found; n++) begin
            @(posedge pclk); #1;
            lane_update(); apply_lanes();
            m_pready = 0; m_pslverr = 0; m_prdata = DW'($urandom);
            #1;
            chk("idle_psel", m_psel, 0);     chk("idle_penable", m_penable, 0);
            chk("idle_grant", grant, 0);     chk("idle_busy", busy, 0);
            chk("idle_pready", s_pready, 0);
            found = (s_psel != '0);
        end
        if (!found) begin
            checks++; failures++;
            $error("FAIL no_request: observed=none expected=a request within 40 cycles");
            return;
        end
        w = pick(s_psel, ptr);
        for (int i = 0; i < N; i++)
            if (s_psel[i] && i != w) begin
                waited[i]++;
                chk("fairness_bound", waited[i] <= N - 1, 1);
            end
        waited[w] = 0;
        owner = w;
        oh = N'(1) << w;
        ewr = req_wr[w]; ea = req_addr[w]; ed = req_wdata[w]; es = req_strb[w]; ep = req_prot[w];

        @(posedge pclk); #1;
        lane_update(); apply_lanes();
        #1;
        chk("setup_psel", m_psel, 1);    chk("setup_penable", m_penable, 0);
        chk("setup_grant", grant, oh);   chk("setup_busy", busy, 1);
        chk("setup_pwrite", m_pwrite, ewr); chk("setup_paddr", m_paddr, ea);
        chk("setup_pwdata", m_pwdata, ed);  chk("setup_pstrb", m_pstrb, es);
        chk("setup_pprot", m_pprot, ep);    chk("setup_pready", s_pready, 0);

        fin = 0;
        for (int j = 0; j < TO && !fin; j++) begin
            @(posedge pclk); #1;
            lane_update();
            if (rand_mode && req_act[w] && $urandom_range(0, 15) == 0) begin
                req_act[w] = 0; req_en[w] = 0;
            end
            apply_lanes();
            m_pready  = (j == waits);
            m_pslverr = err;
            m_prdata  = fix_rd ? rd : DW'($urandom);
            to  = !m_pready && (j == TO - 1);
            fin = m_pready || to;
            #1;
            chk("access_psel", m_psel, 1);   chk("access_penable", m_penable, 1);
            chk("access_grant", grant, oh);  chk("access_busy", busy, 1);
            chk("access_paddr", m_paddr, ea); chk("access_pwdata", m_pwdata, ed);
            exp_rdy = (fin && req_act[w]) ? oh : '0;
            chk("s_pready", s_pready, exp_rdy);
            chk("s_pslverr", s_pslverr, (fin && req_act[w] && (to || err)) ? oh : '0);
            if (fin) chk("s_prdata", s_prdata, to ? '0 : m_prdata);
            last_rdy = exp_rdy;
        end
        ptr = (w + 1) % N;
        last_w = w;
        owner = -1;
    endtask

    initial begin
        do_reset();
        check_zero();

        // Single zero-wait write on lane 0
        set_req(0, 1, 32'h10, 32'hDEADBEEF, 4'hF, 3'h0);
        run_transfer(0, 0, 0, '0);
        chk("single_winner", last_w, 0);

        // Lanes 0 and 1 held continuously: grants alternate
        do_reset();
        hold_mode = 1;
        set_req(0, 1, 32'h100, 32'h11, 4'h3, 3'h1);
        set_req(1, 0, 32'h200, 32'h22, 4'hC, 3'h2);
        for (int k = 0; k < 4; k++) begin
            run_transfer(0, 0, 0, '0);
            chk("alternate_winner", last_w, k % 2);
        end

        // Read with 3 slave waits and an error response
        do_reset();
        set_req(1, 0, 32'h30, 32'h0, 4'h0, 3'h2);
        run_transfer(3, 1, 1, 32'hA5A50001);
        chk("read_err_winner", last_w, 1);

        // Hung slave: timeout, then the next requester is served at once
        do_reset();
        set_req(0, 1, 32'h44, 32'h55, 4'hF, 3'h0);
        set_req(2, 0, 32'h88, 32'h0, 4'h0, 3'h5);
        run_transfer(100, 0, 0, '0);
        chk("timeout_winner", last_w, 0);
        run_transfer(0, 0, 0, '0);
        chk("after_timeout_winner", last_w, 2);

        // Ready on the last counter value completes normally; then wrap from rr_ptr=0
        do_reset();
        set_req(3, 1, 32'h77, 32'h99, 4'h1, 3'h0);
        run_transfer(TO - 1, 0, 0, '0);
        chk("boundary_winner", last_w, 3);
        @(posedge pclk); #1;
        lane_update(); apply_lanes(); m_pready = 0;
        set_req(1, 0, 32'h11, 32'h0, 4'h0, 3'h0);
        set_req(3, 0, 32'h33, 32'h0, 4'h0, 3'h0);
        run_transfer(0, 0, 0, '0);
        chk("wrap_winner", last_w, 1);

        // Reset asserted during ACCESS
        do_reset();
        set_req(2, 1, 32'h40, 32'h1234, 4'hF, 3'h7);
        @(posedge pclk); #1; lane_update(); apply_lanes(); #1;
        @(posedge pclk); #1; lane_update(); apply_lanes(); #1;
        chk("mid_setup_psel", m_psel, 1);
        @(posedge pclk); #1; lane_update(); apply_lanes(); m_pready = 0; #1;
        chk("mid_access_penable", m_penable, 1);
        presetn = 0;
        #1;
        check_zero();
        do_reset();
        set_req(1, 1, 32'h50, 32'hCAFE, 4'h3, 3'h0);
        run_transfer(1, 0, 0, '0);
        chk("post_reset_winner", last_w, 1);

        // Randomized traffic
        do_reset();
        rand_mode = 1;
        for (int t = 0; t < 300; t++)
            run_transfer(($urandom_range(0, 5) == 0) ? int'($urandom_range(6, 12))
                                                     : int'($urandom_range(0, 3)),
                         1'($urandom_range(0, 1)), 0, '0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
